sad_block_engine: RTL

//  Streaming 8x8 SAD unit: computes the sum of absolute differences between one block of the present frame and one candidate block of the next frame.

---
 rtl/sad_block_engine.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sad_block_engine.sv
// sad_block_engine -- streaming BLKxBLK sum of absolute differences over two
// single-port frame memories with 1-cycle read latency (rev 1.0).
`default_nettype none

module sad_block_engine #(
   parameter int H   = 320,
   parameter int V   = 240,
   parameter int BLK = 8,
   parameter int N   = 12,
   parameter int S   = 10,
   parameter int AW  = 17
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [S-1:0]  req_px,
   input  logic [S-1:0]  req_py,
   input  logic [S-1:0]  req_nx,
   input  logic [S-1:0]  req_ny,
   output logic          cur_rd_en,
   output logic [AW-1:0] cur_addr,
   input  logic [N-1:0]  cur_data,
   output logic          nxt_rd_en,
   output logic [AW-1:0] nxt_addr,
   input  logic [N-1:0]  nxt_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N+5:0]  out_sad
);

   localparam int PAD  = BLK / 2;
   localparam int NPIX = BLK * BLK;
   localparam int KW   = $clog2(NPIX);
   localparam int SW   = N + 6;
   localparam logic [KW-1:0] K_LAST = KW'(NPIX - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state, state_next;

   logic [S-1:0]  px, py, nx, ny;
   logic [KW-1:0] k;
   logic [S-1:0]  sx, sy, cx, cy, ncx, ncy;
   logic          cur_in, nxt_in;
   logic          issue_d1, issue_d2;
   logic          cur_in_d1, cur_in_d2, nxt_in_d1, nxt_in_d2;
   logic [N-1:0]  pix_a, pix_b, abs_diff;
   logic [SW-1:0] acc;
   logic          accept;

   function automatic logic in_frame(input logic [S-1:0] x, input logic [S-1:0] y);
      return (x >= S'(PAD)) && (x <= S'(H + PAD - 1)) &&
             (y >= S'(PAD)) && (y <= S'(V + PAD - 1));
   endfunction

   function automatic logic [AW-1:0] frame_addr(input logic [S-1:0] x, input logic [S-1:0] y);
      logic [S-1:0] fx;
      logic [S-1:0] fy;
      fx = x - S'(PAD);
      fy = y - S'(PAD);
      return AW'(fx) + AW'(fy) * AW'(H);
   endfunction

   // Raster walk inside the block; coordinate sums wrap modulo 2^S.
   assign sx  = S'(k % KW'(BLK));
   assign sy  = S'(k / KW'(BLK));
   assign cx  = px + sx;
   assign cy  = py + sy;
   assign ncx = nx + sx;
   assign ncy = ny + sy;

   assign cur_in = in_frame(cx, cy);
   assign nxt_in = in_frame(ncx, ncy);

   assign accept    = (state == IDLE) && req_valid;
   assign req_ready = (state == IDLE);
   assign out_valid = (state == DONE);
   assign out_sad   = acc;

   // Padding pixels substitute all-ones in place of whatever the memory returned.
   assign pix_a    = cur_in_d2 ? cur_data : {N{1'b1}};
   assign pix_b    = nxt_in_d2 ? nxt_data : {N{1'b1}};
   assign abs_diff = (pix_a >= pix_b) ? (pix_a - pix_b) : (pix_b - pix_a);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // DRAIN spans two cycles so the final read reaches the accumulator.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req_valid)         state_next = ISSUE;
         ISSUE:   if (k == K_LAST)       state_next = DRAIN;
         DRAIN:   if (k == KW'(1))       state_next = DONE;
         DONE:    if (out_ready)         state_next = IDLE;
         default:                        state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         px        <= '0;
         py        <= '0;
         nx        <= '0;
         ny        <= '0;
         k         <= '0;
         cur_rd_en <= 1'b0;
         cur_addr  <= '0;
         nxt_rd_en <= 1'b0;
         nxt_addr  <= '0;
         issue_d1  <= 1'b0;
         issue_d2  <= 1'b0;
         cur_in_d1 <= 1'b0;
         cur_in_d2 <= 1'b0;
         nxt_in_d1 <= 1'b0;
         nxt_in_d2 <= 1'b0;
         acc       <= '0;
      end else begin
         if (accept) begin
            px <= req_px;
            py <= req_py;
            nx <= req_nx;
            ny <= req_ny;
         end

         if (((state == ISSUE) && (k != K_LAST)) || (state == DRAIN)) begin
            k <= k + KW'(1);
         end else begin
            k <= '0;
         end

         cur_rd_en <= (state == ISSUE) && cur_in;
         cur_addr  <= ((state == ISSUE) && cur_in) ? frame_addr(cx, cy) : '0;
         nxt_rd_en <= (state == ISSUE) && nxt_in;
         nxt_addr  <= ((state == ISSUE) && nxt_in) ? frame_addr(ncx, ncy) : '0;

         // In-frame flags ride two stages to line up with returned data.
         issue_d1  <= (state == ISSUE);
         issue_d2  <= issue_d1;
         cur_in_d1 <= cur_in;
         cur_in_d2 <= cur_in_d1;
         nxt_in_d1 <= nxt_in;
         nxt_in_d2 <= nxt_in_d1;

         if (accept) begin
            acc <= '0;
         end else if (issue_d2) begin
            acc <= acc + SW'(abs_diff);
         end
      end
   end

endmodule

`default_nettype wire
